reg_access_master: RTL
======================

Name: reg_access_master

Overview:
- Initiator for the 16-bit read/write storage register: the block that drives the register's rw, ip, clk and reset inputs, and receives its op output.
- Accepts single-word requests from upstream with a valid/ready handshake: write, read, or write-with-readback-verify.
- Sequences the register's one-cycle write and registered read.
- Returns a response with a valid/ready handshake, keeps a transaction count, and keeps a sticky verify-error flag.

Parameters:
- WIDTH, 16, data width; matches the storage register.
- CNT_W, 8, width of the completed-transaction counter.

Ports:
- clk  input  1  system clock; all state updates on posedge.
- reset  input  1  asynchronous, active-high reset.
- req_valid  input  1  request present.
- req_ready  output  1  block can accept a request (high only in IDLE).
- req_write  input  1  1 = write, 0 = read.
- req_verify  input  1  with req_write = 1: read back after the write and compare. Ignored for reads.
- req_data  input  WIDTH  write data.
- resp_valid  output  1  response present.
- resp_ready  input  1  downstream accepts the response.
- resp_data  output  WIDTH  read or readback data; the written data for a plain write.
- resp_err  output  1  verify mismatch for this response.
- err_sticky  output  1  set on any verify mismatch; cleared only by reset.
- txn_count  output  CNT_W  number of completed response handshakes; wraps.
- reg_rw  output  1  to register rw: 1 = write on this edge, 0 = read.
- reg_ip  output  WIDTH  to register ip.
- reg_op  input  WIDTH  from register op; updated at the edge ending a cycle with reg_rw = 0.

Behaviour:
- Reset (async, active-high) forces:
  - state = IDLE
  - resp_valid = 0, resp_data = 0, resp_err = 0, err_sticky = 0, txn_count = 0
  - reg_rw = 0, reg_ip = 0
  - req_ready therefore = 1
- Reset mid-transaction: the transaction is abandoned with no response and no count. The register shares the same reset, so its stored value is also 0.
- reg_rw is 1 only in state WR. In every other state reg_rw = 0, so the register performs harmless reads. reg_ip holds the latched request data.
- States:
  - IDLE: req_ready = 1. On req_valid at a posedge: latch req_data, req_write and (req_verify & req_write). Go to WR if write, else RD.
  - WR: reg_rw = 1, reg_ip = latched data; the register stores it at the end of this cycle. Go to RD if verify, else RESP with resp_data = latched data and resp_err = 0.
  - RD: reg_rw = 0; the register's op updates at the end of this cycle. Go to CAP.
  - CAP: sample reg_op into resp_data at the end of this cycle.
    - If verify: resp_err = (reg_op != latched data), and err_sticky |= resp_err.
    - Go to RESP.
  - RESP: resp_valid = 1. Outputs hold stable until resp_ready. On resp_valid & resp_ready: txn_count += 1 (mod 2^CNT_W), resp_valid drops, go to IDLE.
- Latency, acceptance edge to first resp_valid cycle:
  - write: 2 cycles
  - read: 3 cycles
  - write+verify: 4 cycles
- Throughput: one transaction in flight. A new request is accepted no earlier than the cycle after the response handshake; there is no bypass from RESP to IDLE acceptance.
- Requests arriving outside IDLE see req_ready = 0 and must be held by the source; they are never dropped.
- txn_count wraps from all-ones to 0 with no flag.
- req_verify on a read is ignored: resp_err = 0.

Decomposition:
- Shared package holds:
  - the state enum: IDLE, WR, RD, CAP, RESP
  - REG_WIDTH = 16 default
  - the rw encoding constants RW_WRITE = 1, RW_READ = 0, shared with the storage register
- No sub-module. Benches instantiate this block together with the storage register.

Test Plan:
- Reset, then idle 3 cycles -> req_ready = 1, resp_valid = 0, txn_count = 0, reg_rw = 0.
- Write 16'h6FA7, then read -> write response: resp_data = 16'h6FA7 two cycles after acceptance. Read response: resp_data = 16'h6FA7 three cycles after acceptance. txn_count = 2.
- Write+verify 16'hA5A5 with the register healthy -> resp_err = 0, err_sticky = 0, resp_data = 16'hA5A5, latency 4 cycles.
- Write+verify 16'h0001 with a bench fault forcing reg_op = 16'h0000 -> resp_err = 1, err_sticky = 1 and it remains 1 after a later clean transaction.
- Hold resp_ready = 0 for 5 cycles during a read of 16'h1234 -> resp_valid and resp_data stay stable, req_ready = 0 throughout, txn_count increments only at the handshake.
- Assert reset during RD of a read after writing 16'hFFFF -> outputs return to reset values immediately, with no response. A subsequent read returns 16'h0000.

Source files
------------

// File: rtl/reg_access_master_pkg.sv
`default_nettype none
// ============================================================================
// Module   : reg_access_master_pkg
// Purpose  : Shared definitions for the register access master and the
//            16-bit storage register it drives: FSM state encoding, the
//            default data width and the rw encoding on the register port.
// Revision : 1.0 - initial release
// ============================================================================
package reg_access_master_pkg;

    // Default data width, which matches the storage register.
    localparam int REG_WIDTH = 16;

    // Encoding of the register rw input.
    localparam logic RW_WRITE = 1'b1;
    localparam logic RW_READ  = 1'b0;

    // Transaction sequencer states.
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        WR   = 3'd1,
        RD   = 3'd2,
        CAP  = 3'd3,
        RESP = 3'd4
    } state_t;

endpackage
`default_nettype wire

// File: rtl/reg_access_master.sv
`default_nettype none
// ============================================================================
// Module   : reg_access_master
// Purpose  : Initiator for the 16-bit read/write storage register. It accepts
//            one request at a time (write, read, or write with readback
//            verify), sequences the register's one-cycle write and registered
//            read, and returns a response. It also keeps a count of completed
//            responses and a sticky verify-error flag.
// Ports    : clk, reset            - clock, async active-high reset
//            req_valid/req_ready   - request handshake
//            req_write/req_verify  - request kind
//            req_data              - write data
//            resp_valid/resp_ready - response handshake
//            resp_data/resp_err    - response payload
//            err_sticky            - any verify mismatch since reset
//            txn_count             - completed response handshakes (wraps)
//            reg_rw/reg_ip/reg_op  - storage register interface
// Revision : 1.0 - initial release
// ============================================================================
module reg_access_master
    import reg_access_master_pkg::*;
#(
    parameter int WIDTH = REG_WIDTH,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_write,
    input  logic             req_verify,
    input  logic [WIDTH-1:0] req_data,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [WIDTH-1:0] resp_data,
    output logic             resp_err,
    output logic             err_sticky,
    output logic [CNT_W-1:0] txn_count,
    output logic             reg_rw,
    output logic [WIDTH-1:0] reg_ip,
    input  logic [WIDTH-1:0] reg_op
);

    state_t           state;
    state_t           state_next;

    logic [WIDTH-1:0] lat_data;
    logic             lat_write;
    logic             lat_verify;

    // Verify compare is only meaningful in CAP of a verify transaction.
    logic             mismatch;
    assign mismatch = lat_verify && (reg_op != lat_data);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and Moore outputs
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        reg_rw     = RW_READ;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    state_next = req_write ? WR : RD;
                end
            end
            WR: begin
                reg_rw     = RW_WRITE;
                state_next = lat_verify ? RD : RESP;
            end
            RD: begin
                state_next = CAP;
            end
            CAP: begin
                state_next = RESP;
            end
            RESP: begin
                resp_valid = 1'b1;
                if (resp_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Request latch, response payload, counter and sticky error
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lat_data   <= '0;
            lat_write  <= 1'b0;
            lat_verify <= 1'b0;
            resp_data  <= '0;
            resp_err   <= 1'b0;
            err_sticky <= 1'b0;
            txn_count  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        lat_data   <= req_data;
                        lat_write  <= req_write;
                        // Verify only applies to writes.
                        lat_verify <= req_verify & req_write;
                    end
                end
                WR: begin
                    // A plain write answers with the data it wrote.
                    if (!lat_verify) begin
                        resp_data <= lat_data;
                        resp_err  <= 1'b0;
                    end
                end
                CAP: begin
                    // reg_op now reflects the read issued in RD.
                    resp_data <= reg_op;
                    resp_err  <= mismatch;
                    if (mismatch) begin
                        err_sticky <= 1'b1;
                    end
                end
                RESP: begin
                    if (resp_ready) begin
                        txn_count <= txn_count + CNT_W'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // The register sees the latched data for the whole transaction.
    assign reg_ip = lat_data;

endmodule
`default_nettype wire
